sdp_ram_be_clr: RTL and testbench
=================================

# sdp_ram_be_clr

Single-clock simple dual-port RAM for match-action lookup and action tables. It adds four things to the plain write-port/read-port RAM: per-byte write enables, same-cycle read-during-write forwarding, a selectable 1- or 2-cycle read pipeline with a valid flag, and a hardware clear sequence after reset. Table-update logic drives the write port; the stage lookup pipeline drives the read port.

## Interface
- DATA_WIDTH, default 64: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, default 4: depth is 2**ADDR_WIDTH words.
- BYTE_WIDTH, default 8: bits covered by each write-enable bit.
- READ_LATENCY, default 1: 1 or 2; any other value is a configuration error (elaboration-time check).
- INIT_CLEAR, default 1: 1 = zero all words after reset; 0 = no clear, contents retained.
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/BYTE_WIDTH  byte enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  rd_data updated this cycle by an accepted read.
- init_done  output  1  RAM ready; port requests accepted only while high.

## Operation
- FSM states: CLEAR and READY.
  - Reset enters CLEAR when INIT_CLEAR=1, READY when INIT_CLEAR=0.
  - CLEAR: clr_addr counts 0..2**ADDR_WIDTH-1, writing all-zero words, one address per cycle. After the last address, go to READY.
  - READY is terminal until the next rst.
- While in CLEAR:
  - wr_en and rd_en are ignored and dropped, not queued.
  - rd_valid stays 0.
- Write in READY (wr_en=1): only bytes with wr_be[i]=1 are updated; the other bytes keep their old value. wr_en=1 with wr_be=0 is a no-op.
- Read in READY (rd_en=1): reads word rd_addr.
- Read-during-write, same cycle, rd_addr==wr_addr, both enabled: the read returns the merged new word. Enabled bytes come from wr_data; the rest come from the array (write-first).
- Read-during-write, different addresses: the two accesses are independent.
- Read with rd_en=0: rd_data holds its last value and rd_valid=0.
- Reset values: rd_data=0, rd_valid=0, init_done=0 (INIT_CLEAR=1) or 1 (INIT_CLEAR=0), clr_addr=0. Pipeline registers are cleared. Array contents are not reset except by the CLEAR sequence.
- rst asserted mid-operation: in-flight reads are flushed (no rd_valid). When INIT_CLEAR=1, clearing restarts from address 0.
- Widths: clr_addr is ADDR_WIDTH+1 bits so the terminal count needs no wrap compare. Addresses are never out of range.

## Timing
- Cycle numbering: cycle 0 is the first cycle with rst=0.
- INIT_CLEAR=1:
  - Address k is cleared in cycle k.
  - init_done rises at the edge ending cycle 2**ADDR_WIDTH-1.
  - The first accepted request is in cycle 2**ADDR_WIDTH.
- INIT_CLEAR=0: init_done=1 from cycle 0, and requests are accepted in cycle 0.
- Write: the array is updated at the edge ending the request cycle. A read of the same address in the next cycle sees the new data.
- READ_LATENCY=1: rd_data and rd_valid are valid in cycle N+1 for a request in cycle N.
- READ_LATENCY=2: rd_data and rd_valid are valid in cycle N+2 for a request in cycle N.
- Ordering with READ_LATENCY=2: a write issued in cycle N+1 to the address read in cycle N does not affect that read's result.
- Throughput: one read and one write per cycle, sustained, no stalls.
- rd_valid is exactly rd_en & init_done delayed by READ_LATENCY cycles.

## Test plan
- Clear sweep, ADDR_WIDTH=4, INIT_CLEAR=1:
  - Preload every word with 0xFF..FF.
  - Pulse rst, then hold rd_en=1 at addr 3 from cycle 0.
  - init_done rises after 16 cycles; no rd_valid before cycle 16.
  - The read in cycle 16 returns 0 at cycle 17 (READ_LATENCY=1).
- Byte enables:
  - Write 0x1122334455667788 to addr 5 with wr_be=0xFF, then 0xAABBCCDDEEFF0011 with wr_be=0x0F.
  - Reading addr 5 returns 0x11223344EEFF0011.
- Same-cycle forwarding:
  - addr 7 holds 0x0.
  - In one cycle, write 0xDEAD with wr_be=0x03 and read addr 7.
  - rd_data=0x000000000000DEAD after READ_LATENCY cycles.
- Latency 2 pipeline:
  - Back-to-back reads of addrs 1, 2, 3 holding 10, 20, 30.
  - rd_valid is high for 3 cycles starting cycle N+2, with data 10, 20, 30 in order.
  - A write of 99 to addr 1 in cycle N+1 still yields 10 for the first read.
- Reset mid-clear and mid-read:
  - Assert rst at clear cycle 9 and while a read is in flight.
  - No rd_valid appears, init_done stays 0, and clearing restarts from addr 0 (16 further cycles).
- Requests during CLEAR are dropped:
  - wr_en=1 to addr 2 with 0x55 in cycle 1.
  - After init_done, reading addr 2 returns 0.

Source files
------------

// File: rtl/sdp_ram_be_clr.sv
// Simple dual-port RAM for lookup/action tables. It has byte-enabled writes, write-first
// forwarding, a 1- or 2-cycle registered read, and a zero-fill sweep after reset.
module sdp_ram_be_clr #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 4,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_done
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH:0]     clr_addr;
  logic [ADDR_WIDTH:0]     clr_addr_inc;
  logic                    clearing;
  logic                    ready;
  logic                    wr_fire;
  logic                    rd_fire;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sdp_ram_be_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  // The extra MSB of the sweep counter flags the terminal count directly.
  assign clr_addr_inc = clr_addr + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_CLEAR != 0) ? CLEAR : READY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_addr_inc[ADDR_WIDTH]) state_next = READY;
      READY:   state_next = READY;
      default: state_next = state;
    endcase
  end

  always_comb begin
    clearing = (state == CLEAR);
    ready    = (state == READY);
  end

  assign init_done = ready;
  assign wr_fire   = ready & wr_en;
  assign rd_fire   = ready & rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
    end else if (clearing) begin
      clr_addr <= clr_addr_inc;
    end
  end

  // The array has no reset. Only the sweep zeroes it, and only outside rst cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem[clr_addr[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wr_be[i]) begin
            mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Write-first: enabled bytes of a same-address write bypass the array.
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_word;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rd_data  = s2_data;
    assign rd_valid = s2_valid;
  end else begin : g_bad_latency
    $error("sdp_ram_be_clr: READ_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_sdp_ram_be_clr.sv
// Bench for sdp_ram_be_clr: latency-1 and latency-2 instances share one stimulus stream,
// and a reference model with per-instance scoreboards predicts their outputs.
module tb_sdp_ram_be_clr;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int NB    = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          rd_valid1;
  logic          rd_valid2;
  logic          init_done1;
  logic          init_done2;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last1;
  logic [DW-1:0] last2;
  int            total;
  int            bad;
  int            tcount;
  int            m_clr;
  bit            m_ready;
  bit            armed;

  always #5 clk = ~clk;

  sdp_ram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .READ_LATENCY(1), .INIT_CLEAR(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1)
  );

  sdp_ram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .READ_LATENCY(2), .INIT_CLEAR(1)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .init_done(init_done2)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, tcount);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] o;
    o = old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) o[i*8 +: 8] = d[i*8 +: 8];
    end
    return o;
  endfunction

  // One clock cycle. At the negedge the task checks the outputs of the previous edge,
  // advances the model with this cycle's inputs, then drives those inputs.
  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [NB-1:0] be,
                               input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] rw;
    exp_t          e;
    bit            ev;
    @(negedge clk);
    if (armed) begin
      checkOutput("init_done_l1", {63'b0, init_done1}, {63'b0, m_ready});
      checkOutput("init_done_l2", {63'b0, init_done2}, {63'b0, m_ready});
      ev = (q1.size() > 0) && (q1[0].due == tcount);
      checkOutput("valid_l1", {63'b0, rd_valid1}, {63'b0, ev});
      if (ev) begin
        e = q1.pop_front();
        checkOutput("data_l1", rd_data1, e.data);
        last1 = e.data;
      end else begin
        checkOutput("hold_l1", rd_data1, last1);
      end
      ev = (q2.size() > 0) && (q2[0].due == tcount);
      checkOutput("valid_l2", {63'b0, rd_valid2}, {63'b0, ev});
      if (ev) begin
        e = q2.pop_front();
        checkOutput("data_l2", rd_data2, e.data);
        last2 = e.data;
      end else begin
        checkOutput("hold_l2", rd_data2, last2);
      end
    end
    if (r) begin
      q1.delete();
      q2.delete();
      m_ready = 1'b0;
      m_clr   = 0;
      last1   = '0;
      last2   = '0;
      armed   = 1'b1;
    end else if (!m_ready) begin
      mdl[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_ready = 1'b1;
    end else begin
      if (re) begin
        rw = mdl[ra];
        if (we && (wa == ra)) rw = merge(rw, wd, be);
        e.data = rw;
        e.due  = tcount + 1;
        q1.push_back(e);
        e.due  = tcount + 2;
        q2.push_back(e);
      end
      if (we) mdl[wa] = merge(mdl[wa], wd, be);
    end
    rst     = r;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    @(posedge clk);
    tcount++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_en = 1'b0; rd_addr = '0;
    total = 0; bad = 0; tcount = 0; m_clr = 0; m_ready = 1'b0; armed = 1'b0;
    last1 = '0; last2 = '0;

    applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 8'd0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 8'd0, 1'b0, 4'd0);

    // Requests made during the sweep must be dropped.
    for (int c = 0; c < 16; c++)
      applyStimulus(1'b0, c == 1, 4'd2, 64'h55, 8'hFF, c == 3, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd4, 64'h1234, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd4);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd2);
    idle(3);
    checkOutput("dropped_wr_l1", rd_data1, 64'd0);
    checkOutput("dropped_wr_l2", rd_data2, 64'd0);

    // Fill every word with ones, then reset while a read is held on address 3.
    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b0, 1'b1, 4'(a), '1, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 8'd0, 1'b0, 4'd0);
    for (int c = 0; c < 19; c++)
      applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd3);
    idle(2);

    // Byte enables.
    applyStimulus(1'b0, 1'b1, 4'd5, 64'h1122334455667788, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd5, 64'hAABBCCDDEEFF0011, 8'h0F, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd5);
    idle(3);
    checkOutput("byte_en_l1", rd_data1, 64'h11223344EEFF0011);
    checkOutput("byte_en_l2", rd_data2, 64'h11223344EEFF0011);

    // Same-cycle write/read forwarding.
    applyStimulus(1'b0, 1'b1, 4'd7, 64'hDEAD, 8'h03, 1'b1, 4'd7);
    idle(3);
    checkOutput("forward_l1", rd_data1, 64'h000000000000DEAD);
    checkOutput("forward_l2", rd_data2, 64'h000000000000DEAD);

    // Back-to-back reads, plus a write to the first address one cycle later.
    applyStimulus(1'b0, 1'b1, 4'd1, 64'd10, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd2, 64'd20, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd3, 64'd30, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd1);
    applyStimulus(1'b0, 1'b1, 4'd1, 64'd99, 8'hFF, 1'b1, 4'd2);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd3);
    idle(3);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd1);
    idle(3);
    checkOutput("rewrite_l1", rd_data1, 64'd99);
    checkOutput("rewrite_l2", rd_data2, 64'd99);

    // Reset with a read in flight, then reset again at sweep cycle 9.
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd5);
    for (int c = 0; c < 9; c++)
      applyStimulus(1'b0, 1'b1, 4'(c), 64'hAB, 8'hFF, 1'b1, 4'(c));
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 8'd0, 1'b0, 4'd0);
    for (int c = 0; c < 16; c++)
      applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'(c));
    applyStimulus(1'b0, 1'b1, 4'd9, 64'hABC, 8'hFF, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd9);
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 1'b1, 4'd5);
    idle(3);
    checkOutput("reclear_l1", rd_data1, 64'd0);
    checkOutput("reclear_l2", rd_data2, 64'd0);

    // Random concurrent traffic.
    for (int c = 0; c < 300; c++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    {$urandom(), $urandom()}, 8'($urandom()),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    idle(4);
    checkOutput("drain_l1", 64'(q1.size()), 64'd0);
    checkOutput("drain_l2", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
